// File: rtl/lzc_pkg.sv
// lzc_pkg: shared constants, state encoding and width helper for the chunked LZC
package lzc_pkg;
  localparam int CHUNK_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} lzc_state_e;
  function automatic int cw_of(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/lzc8_slice.sv
// lzc8_slice: combinational MSB-first leading-zero count of one 8-bit chunk
module lzc8_slice (
  input  logic [7:0] chunk,
  output logic [2:0] cnt,
  output logic       all_zero
);
  // priority decode from the MSB; value is 7 (don't care) for a zero chunk
  always_comb begin
    cnt = chunk[7] ? 3'd0 : chunk[6] ? 3'd1 : chunk[5] ? 3'd2 : chunk[4] ? 3'd3 :
          chunk[3] ? 3'd4 : chunk[2] ? 3'd5 : chunk[1] ? 3'd6 : 3'd7;
    all_zero = ~|chunk;
  end
endmodule

// File: rtl/lzc_chunk_sched.sv
// lzc_chunk_sched: multi-cycle leading-zero counter scanning one 8-bit chunk per cycle
module lzc_chunk_sched
  import lzc_pkg::*;
#(
  parameter  int WIDTH  = 32,
  localparam int NCHUNK = WIDTH / CHUNK_W,
  localparam int CW     = cw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_zero
);
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  lzc_state_e       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             zero_q, zero_d;
  logic [2:0]       s_cnt;
  logic             s_zero;
  lzc8_slice u_slice (
    .chunk    (sr_q[WIDTH-1 -: CHUNK_W]),
    .cnt      (s_cnt),
    .all_zero (s_zero)
  );
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_count = cnt_q;
  assign out_zero  = zero_q;
  // next-state: capture in IDLE, one chunk per SCAN cycle, hold in DONE until taken
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        sr_d    = in_data;
        cnt_d   = '0;
        idx_d   = '0;
        state_d = SCAN;
      end
      SCAN: if (!s_zero) begin
        cnt_d   = cnt_q + CW'(s_cnt);
        zero_d  = 1'b0;
        state_d = DONE;
      end else if (idx_q != IW'(NCHUNK - 1)) begin
        cnt_d = cnt_q + CW'(CHUNK_W);
        sr_d  = sr_q << CHUNK_W;
        idx_d = idx_q + 1'b1;
      end else begin
        cnt_d   = CW'(WIDTH);
        zero_d  = 1'b1;
        state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state registers with synchronous active-low reset discarding any in-flight op
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      zero_q  <= zero_d;
    end
  end
endmodule

// File: tb/tb_lzc_chunk_sched.sv
// tb_lzc_chunk_sched: directed self-checking bench for lzc_chunk_sched
module tb_lzc_chunk_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_count;
  logic        out_zero;
  int          n_chk = 0;
  int          n_fail = 0;

  lzc_chunk_sched #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [31:0] d, input string nm);
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_before_accept: got %b want 1", nm, in_ready);
    end
    in_data = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data = ~d;
  endtask

  task automatic wait_done(input logic [5:0] ec, input logic ez, input int en, input string nm);
    int lat = 0;
    bit busy_ok = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      if (in_ready !== 1'b0) busy_ok = 0;
      tick();
      lat++;
    end
    n_chk++;
    if (lat != en) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges want %0d", nm, lat, en);
    end
    n_chk++;
    if (!busy_ok || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s in_ready_busy: got high during SCAN/DONE want low", nm);
    end
    n_chk++;
    if (out_count !== ec || out_zero !== ez) begin
      n_fail++;
      $display("FAIL %s result: got count=%0d zero=%b want count=%0d zero=%b", nm, out_count, out_zero, ec, ez);
    end
  endtask

  task automatic release_out(input string nm);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s back_to_idle: got valid=%b ready=%b want valid=0 ready=1", nm, out_valid, in_ready);
    end
  endtask

  task automatic do_op(input logic [31:0] d, input logic [5:0] ec, input logic ez, input int en, input string nm);
    accept(d, nm);
    wait_done(ec, ez, en, nm);
    release_out(nm);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 6'd0 || out_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got ready=%b valid=%b count=%0d zero=%b want 1 0 0 0", in_ready, out_valid, out_count, out_zero);
    end
  endtask

  task automatic test_counts();
    do_op(32'h8000_0000, 6'd0, 1'b0, 1, "msb_set");
    do_op(32'h0001_0000, 6'd15, 1'b0, 2, "chunk1");
    do_op(32'h0000_0001, 6'd31, 1'b0, 4, "lsb_set");
    do_op(32'h0000_0100, 6'd23, 1'b0, 3, "chunk2");
    do_op(32'h0F00_0000, 6'd4, 1'b0, 1, "mid_bit");
  endtask

  task automatic test_back_to_back();
    do_op(32'h0000_0000, 6'd32, 1'b1, 4, "all_zero");
    do_op(32'hFFFF_FFFF, 6'd0, 1'b0, 1, "all_ones");
  endtask

  task automatic test_backpressure();
    accept(32'h0000_4000, "bp");
    wait_done(6'd17, 1'b0, 3, "bp");
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data = 32'h8000_0000;
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || out_count !== 6'd17 || in_ready !== 1'b0 || out_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got valid=%b count=%0d ready=%b zero=%b want 1 17 0 0", i, out_valid, out_count, in_ready, out_zero);
      end
    end
    in_valid = 1'b0;
    release_out("bp");
    tick();
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 6'd17) begin
      n_fail++;
      $display("FAIL bp_idle_hold: got valid=%b ready=%b count=%0d want 0 1 17", out_valid, in_ready, out_count);
    end
  endtask

  task automatic test_reset_mid_op();
    accept(32'h0000_0000, "rst_mid");
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 6'd0 || out_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: got valid=%b ready=%b count=%0d zero=%b want 0 1 0 0", out_valid, in_ready, out_count, out_zero);
    end
    tick();
    tick();
    tick();
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_quiet: got valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
    do_op(32'h0080_0000, 6'd8, 1'b0, 2, "after_rst");
  endtask

  initial begin
    #1;
    test_reset();
    test_counts();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
